// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard signals and the controller's enable/flush outputs.
// master is the controller; slave is the pipeline that feeds it hazard info.
interface hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 4
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [1:0]            id_rs_valid;
  logic [1:0]            ex_cl_mem_op;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_wr;
  logic                  ex_branch_taken;
  logic [1:0]            mem_cl_mem_op;

  logic                  pc_en;
  logic                  en_if_id;
  logic                  en_id_ex;
  logic                  en_ex_mem;
  logic                  en_mem_wb;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic                  flush_mem_wb;
  logic                  mem_busy;
  logic [3:0]            mem_beat;
  logic [15:0]           stall_cycles;

  modport master (
    input  id_rs1, id_rs2, id_rs_valid, ex_cl_mem_op, ex_rd, ex_wr, ex_branch_taken,
           mem_cl_mem_op,
    output pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex,
           flush_mem_wb, mem_busy, mem_beat, stall_cycles
  );

  modport slave (
    output id_rs1, id_rs2, id_rs_valid, ex_cl_mem_op, ex_rd, ex_wr, ex_branch_taken,
           mem_cl_mem_op,
    input  pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex,
           flush_mem_wb, mem_busy, mem_beat, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: vector MEM stalls, branch flushes, load-use
// bubbles, plus a saturating stalled-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MEM_BEATS = 4
) (
  input  logic           clk,
  input  logic           reset,
  hazard_ctrl_if.master  hz
);

  localparam logic [3:0] LastBeat  = 4'(MEM_BEATS - 1);
  localparam bit         MultiBeat = (MEM_BEATS > 1);

  typedef enum logic [0:0] {StIdle, StVbusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [15:0] stall_q, stall_d;

  logic vec_start, vec_stall, last_beat, load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      beat_q  <= 4'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    stall_d         = stall_q;
    hz.pc_en        = 1'b1;
    hz.en_if_id     = 1'b1;
    hz.en_id_ex     = 1'b1;
    hz.en_ex_mem    = 1'b1;
    hz.en_mem_wb    = 1'b1;
    hz.flush_if_id  = 1'b0;
    hz.flush_id_ex  = 1'b0;
    hz.flush_mem_wb = 1'b0;
    hz.mem_busy     = 1'b0;

    vec_start = (state_q == StIdle) && hz.mem_cl_mem_op[1] && MultiBeat;
    vec_stall = vec_start || (state_q == StVbusy);
    last_beat = (state_q == StVbusy) && (beat_q == LastBeat);
    // Only scalar loads raise load-use; vector loads are covered by the MEM stall.
    load_use  = (hz.ex_cl_mem_op == 2'b01) && hz.ex_wr &&
                ((hz.id_rs_valid[0] && (hz.id_rs1 == hz.ex_rd)) ||
                 (hz.id_rs_valid[1] && (hz.id_rs2 == hz.ex_rd)));

    if (reset) begin
      hz.pc_en        = 1'b0;
      hz.flush_if_id  = 1'b1;
      hz.flush_id_ex  = 1'b1;
      hz.flush_mem_wb = 1'b1;
    end else begin
      if (vec_stall) begin
        hz.mem_busy = 1'b1;
      end
      if (vec_stall && !last_beat) begin
        hz.pc_en        = 1'b0;
        hz.en_if_id     = 1'b0;
        hz.en_id_ex     = 1'b0;
        hz.en_ex_mem    = 1'b0;
        hz.flush_mem_wb = 1'b1;
      end else if (hz.ex_branch_taken) begin
        // Held-over branches and load-uses are resolved on the release beat.
        hz.flush_if_id = 1'b1;
        hz.flush_id_ex = 1'b1;
      end else if (load_use) begin
        hz.pc_en       = 1'b0;
        hz.en_if_id    = 1'b0;
        hz.flush_id_ex = 1'b1;
      end
      if (!hz.pc_en && (stall_q != 16'hFFFF)) begin
        stall_d = stall_q + 16'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (vec_start) begin
          state_d = StVbusy;
          beat_d  = 4'd1;
        end
      end
      StVbusy: begin
        if (beat_q == LastBeat) begin
          state_d = StIdle;
          beat_d  = 4'd0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = 4'd0;
      end
    endcase
  end

  assign hz.mem_beat     = beat_q;
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a MEM_BEATS=4 instance for the main scenarios
// and a MEM_BEATS=1 instance that must never stall.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(4)) a_if ();
  hazard_ctrl_if #(.REG_ADDR_W(4)) b_if ();

  hazard_ctrl #(.MEM_BEATS(4)) dut_a (.clk(clk), .reset(reset), .hz(a_if));
  hazard_ctrl #(.MEM_BEATS(1)) dut_b (.clk(clk), .reset(reset), .hz(b_if));

  // {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex, flush_mem_wb,
  //  mem_busy}
  logic [8:0] ctl_a, ctl_b;
  assign ctl_a = {a_if.pc_en, a_if.en_if_id, a_if.en_id_ex, a_if.en_ex_mem, a_if.en_mem_wb,
                  a_if.flush_if_id, a_if.flush_id_ex, a_if.flush_mem_wb, a_if.mem_busy};
  assign ctl_b = {b_if.pc_en, b_if.en_if_id, b_if.en_id_ex, b_if.en_ex_mem, b_if.en_mem_wb,
                  b_if.flush_if_id, b_if.flush_id_ex, b_if.flush_mem_wb, b_if.mem_busy};

  localparam logic [8:0] CtlFree   = 9'b111110000;
  localparam logic [8:0] CtlReset  = 9'b011111110;
  localparam logic [8:0] CtlLdUse  = 9'b001110100;
  localparam logic [8:0] CtlBranch = 9'b111111100;
  localparam logic [8:0] CtlVStall = 9'b000010011;
  localparam logic [8:0] CtlVRel   = 9'b111110001;
  localparam logic [8:0] CtlVRelBr = 9'b111111101;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_a();
    a_if.id_rs1          = 4'd0;
    a_if.id_rs2          = 4'd0;
    a_if.id_rs_valid     = 2'b00;
    a_if.ex_cl_mem_op    = 2'b00;
    a_if.ex_rd           = 4'd0;
    a_if.ex_wr           = 1'b0;
    a_if.ex_branch_taken = 1'b0;
    a_if.mem_cl_mem_op   = 2'b00;
  endtask

  task automatic set_lu_a(input logic [1:0] op, input logic wr, input logic [1:0] vld,
                          input logic [3:0] rs1, input logic [3:0] rs2);
    a_if.ex_cl_mem_op = op;
    a_if.ex_wr        = wr;
    a_if.ex_rd        = 4'd5;
    a_if.id_rs_valid  = vld;
    a_if.id_rs1       = rs1;
    a_if.id_rs2       = rs2;
  endtask

  initial begin
    reset = 1'b1;
    clear_a();
    b_if.id_rs1 = 4'd0; b_if.id_rs2 = 4'd0; b_if.id_rs_valid = 2'b00;
    b_if.ex_cl_mem_op = 2'b00; b_if.ex_rd = 4'd0; b_if.ex_wr = 1'b0;
    b_if.ex_branch_taken = 1'b0; b_if.mem_cl_mem_op = 2'b00;

    // Reset forces outputs
    sample();
    check("reset_ctl", 32'(ctl_a), 32'(CtlReset));
    tick();
    tick();
    reset = 1'b0;
    sample();
    check("post_reset_ctl", 32'(ctl_a), 32'(CtlFree));
    check("post_reset_stall", 32'(a_if.stall_cycles), 32'd0);
    check("post_reset_beat", 32'(a_if.mem_beat), 32'd0);
    tick();

    // Load-use on rs1
    set_lu_a(2'b01, 1'b1, 2'b01, 4'd5, 4'd0);
    sample();
    check("lu_rs1_ctl", 32'(ctl_a), 32'(CtlLdUse));
    tick();
    clear_a();
    sample();
    check("lu_after_ctl", 32'(ctl_a), 32'(CtlFree));
    check("lu_stall1", 32'(a_if.stall_cycles), 32'd1);
    tick();
    // rs1 matches but not marked used
    set_lu_a(2'b01, 1'b1, 2'b00, 4'd5, 4'd5);
    sample();
    check("lu_unused_ctl", 32'(ctl_a), 32'(CtlFree));
    tick();
    // Load-use on rs2
    set_lu_a(2'b01, 1'b1, 2'b10, 4'd3, 4'd5);
    sample();
    check("lu_rs2_ctl", 32'(ctl_a), 32'(CtlLdUse));
    check("lu_unused_stall", 32'(a_if.stall_cycles), 32'd1);
    tick();
    // Vector load in EX never raises load-use
    set_lu_a(2'b10, 1'b1, 2'b01, 4'd5, 4'd0);
    sample();
    check("lu_vec_ctl", 32'(ctl_a), 32'(CtlFree));
    check("lu_rs2_stall", 32'(a_if.stall_cycles), 32'd2);
    tick();
    // Scalar load without a register write
    set_lu_a(2'b01, 1'b0, 2'b01, 4'd5, 4'd0);
    sample();
    check("lu_nowr_ctl", 32'(ctl_a), 32'(CtlFree));
    tick();

    // Branch beats load-use
    set_lu_a(2'b01, 1'b1, 2'b01, 4'd5, 4'd0);
    a_if.ex_branch_taken = 1'b1;
    sample();
    check("br_lu_ctl", 32'(ctl_a), 32'(CtlBranch));
    tick();
    clear_a();

    // Vector load occupies MEM for 4 beats
    a_if.mem_cl_mem_op = 2'b10;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("vld_ctl", 32'(ctl_a), (i == 3) ? 32'(CtlVRel) : 32'(CtlVStall));
      check("vld_beat", 32'(a_if.mem_beat), 32'(i));
      check("vld_stall", 32'(a_if.stall_cycles), 32'(2 + i));
      tick();
    end
    a_if.mem_cl_mem_op = 2'b00;
    sample();
    check("vld_done_ctl", 32'(ctl_a), 32'(CtlFree));
    check("vld_done_stall", 32'(a_if.stall_cycles), 32'd5);
    check("vld_done_beat", 32'(a_if.mem_beat), 32'd0);
    tick();

    // Branch held through a vector store is flushed on the release beat
    a_if.mem_cl_mem_op   = 2'b11;
    a_if.ex_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("vst_br_ctl", 32'(ctl_a), (i == 3) ? 32'(CtlVRelBr) : 32'(CtlVStall));
      tick();
    end
    clear_a();
    sample();
    check("vst_br_stall", 32'(a_if.stall_cycles), 32'd8);
    tick();

    // Back-to-back vector ops retrigger from beat 0
    a_if.mem_cl_mem_op = 2'b10;
    for (int i = 0; i < 8; i++) begin
      sample();
      check("b2b_ctl", 32'(ctl_a), ((i % 4) == 3) ? 32'(CtlVRel) : 32'(CtlVStall));
      check("b2b_beat", 32'(a_if.mem_beat), 32'(i % 4));
      tick();
    end
    a_if.mem_cl_mem_op = 2'b00;
    sample();
    check("b2b_stall", 32'(a_if.stall_cycles), 32'd14);
    tick();

    // Reset at beat 2 of a vector op
    a_if.mem_cl_mem_op = 2'b10;
    tick();
    tick();
    reset = 1'b1;
    sample();
    check("rst_mid_beat", 32'(a_if.mem_beat), 32'd2);
    check("rst_mid_ctl", 32'(ctl_a), 32'(CtlReset));
    tick();
    reset = 1'b0;
    a_if.mem_cl_mem_op = 2'b00;
    sample();
    check("rst_mid_after_ctl", 32'(ctl_a), 32'(CtlFree));
    check("rst_mid_after_beat", 32'(a_if.mem_beat), 32'd0);
    check("rst_mid_after_stall", 32'(a_if.stall_cycles), 32'd0);
    tick();

    // MEM_BEATS=1 never stalls on vector ops
    for (int i = 0; i < 3; i++) begin
      b_if.mem_cl_mem_op = (i == 1) ? 2'b11 : 2'b10;
      sample();
      check("mb1_ctl", 32'(ctl_b), 32'(CtlFree));
      check("mb1_beat", 32'(b_if.mem_beat), 32'd0);
      tick();
    end
    b_if.mem_cl_mem_op = 2'b00;
    sample();
    check("mb1_stall", 32'(b_if.stall_cycles), 32'd0);
    check("free_stall", 32'(a_if.stall_cycles), 32'd0);
    tick();

    // Saturation under a forced continuous load-use stall
    set_lu_a(2'b01, 1'b1, 2'b01, 4'd5, 4'd0);
    sample();
    check("sat_ctl", 32'(ctl_a), 32'(CtlLdUse));
    tick();
    repeat (65533) tick();
    sample();
    check("sat_fffe", 32'(a_if.stall_cycles), 32'h0000FFFE);
    tick();
    sample();
    check("sat_ffff", 32'(a_if.stall_cycles), 32'h0000FFFF);
    repeat (3) tick();
    sample();
    check("sat_hold", 32'(a_if.stall_cycles), 32'h0000FFFF);
    tick();
    clear_a();
    sample();
    check("sat_free_ctl", 32'(ctl_a), 32'(CtlFree));
    check("sat_final", 32'(a_if.stall_cycles), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
